// File: rtl/tank_pkg.sv
// Shared definitions for the tank/sprite pipeline: OAM entry field positions,
// object types and the OAM bank sequencer state encoding.
package tank_pkg;

    localparam int TYPE_HI    = 30;
    localparam int TYPE_LO    = 29;
    localparam int ENABLE_BIT = 28;
    localparam int POS_X_HI   = 27;
    localparam int POS_X_LO   = 18;
    localparam int POS_Y_HI   = 17;
    localparam int POS_Y_LO   = 8;
    localparam int DIR_HI     = 7;
    localparam int DIR_LO     = 6;
    localparam int ROW_HI     = 5;
    localparam int ROW_LO     = 3;
    localparam int COL_HI     = 2;
    localparam int COL_LO     = 0;

    typedef enum logic [1:0] {
        PLAYER   = 2'b00,
        OPPONENT = 2'b01,
        BULLET   = 2'b10
    } obj_type_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } oam_bank_state_t;

endpackage

// File: rtl/oam_bank_mem.sv
// Two-bank OAM register array: one registered read port, one write port whose
// data is either external or the same entry of the opposite bank.
module oam_bank_mem #(
    parameter int W  = 32,
    parameter int D  = 8,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    input  logic          we,
    input  logic          wr_bank,
    input  logic          wr_copy,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data
);

    logic [1:0][D-1:0][W-1:0] banks;
    logic [W-1:0]             wdata;

    assign wdata = wr_copy ? banks[~wr_bank][wr_addr] : wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            banks   <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= banks[rd_bank][rd_addr];
            if (we)
                banks[wr_bank][wr_addr] <= wdata;
        end
    end

endmodule

// File: rtl/oam_bank.sv
// Double-buffered OAM: game logic fills the back bank, a commit publishes it at
// the next frame_end, then the new back bank is resynced from the new front.
// Build option OAM_BANK_CLEAR_EN: the resync pass zeroes the back bank instead.
module oam_bank
    import tank_pkg::*;
#(
    parameter int OAM_WIDTH = 32,
    parameter int OAM_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(OAM_DEPTH)-1:0] wr_addr,
    input  logic [OAM_WIDTH-1:0]         wr_data,
    input  logic                         commit,
    input  logic                         frame_end,
    input  logic [$clog2(OAM_DEPTH)-1:0] rd_addr,
    output logic [OAM_WIDTH-1:0]         rd_data,
    output logic                         swap_pending,
    output logic                         swapped,
    output logic                         bank_sel
);

    localparam int AW = $clog2(OAM_DEPTH);

    oam_bank_state_t state, state_nxt;
    logic            bank_sel_nxt, swapped_nxt;
    logic [AW-1:0]   idx, idx_nxt;

    logic            mem_we, mem_copy;
    logic [AW-1:0]   mem_addr;
    logic [OAM_WIDTH-1:0] mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bank_sel <= 1'b0;
            idx      <= '0;
            swapped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bank_sel <= bank_sel_nxt;
            idx      <= idx_nxt;
            swapped  <= swapped_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bank_sel_nxt = bank_sel;
        idx_nxt      = idx;
        swapped_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit)
                    state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (frame_end) begin
                    state_nxt    = ST_COPY;
                    bank_sel_nxt = ~bank_sel;
                    idx_nxt      = '0;
                    swapped_nxt  = 1'b1;
                end
            end
            ST_COPY: begin
                idx_nxt = idx + 1'b1;
                // terminal compare rather than relying on wrap of idx
                if (idx == AW'(OAM_DEPTH - 1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_ready     = (state == ST_IDLE);
    assign swap_pending = (state == ST_PENDING);

    // Back bank is always ~bank_sel; during COPY bank_sel already names the new front.
    assign mem_we   = (wr_ready && wr_valid) || (state == ST_COPY);
    assign mem_addr = (state == ST_COPY) ? idx : wr_addr;
`ifdef OAM_BANK_CLEAR_EN
    assign mem_copy  = 1'b0;
    assign mem_wdata = (state == ST_COPY) ? '0 : wr_data;
`else
    assign mem_copy  = (state == ST_COPY);
    assign mem_wdata = wr_data;
`endif

    oam_bank_mem #(
        .W (OAM_WIDTH),
        .D (OAM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_bank (bank_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .we      (mem_we),
        .wr_bank (~bank_sel),
        .wr_copy (mem_copy),
        .wr_addr (mem_addr),
        .wr_data (mem_wdata)
    );

endmodule

// File: tb/tb_oam_bank.sv
// Self-checking bench for oam_bank: directed vector table, corner-case
// sequences and randomized traffic against an array-based bank model.
module tb_oam_bank;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, commit, frame_end;
    logic        wr_ready, swap_pending, swapped, bank_sel;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;

    oam_bank dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .frame_end(frame_end),
        .rd_addr(rd_addr), .rd_data(rd_data), .swap_pending(swap_pending),
        .swapped(swapped), .bank_sel(bank_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: two banks of entries, which one is the front, and swap progress
    logic [31:0] mb [2][D];
    int          msel, mcopy;
    bit          mpend, msw;
    logic [31:0] mrd;

    typedef struct {
        logic        wv;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        cm, fe;
        logic [2:0]  ra;
        logic [31:0] e_rd;
        logic        e_sel, e_rdy, e_sw, e_pend;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < D; i++) mb[b][i] = '0;
        msel = 0; mcopy = 0; mpend = 0; msw = 0; mrd = '0;
    endtask

    task automatic model_step();
        int k;
        mrd = mb[msel][rd_addr];
        msw = 0;
        if (mcopy > 0) begin
            k = D - mcopy;
`ifdef OAM_BANK_CLEAR_EN
            mb[msel ^ 1][k] = '0;
`else
            mb[msel ^ 1][k] = mb[msel][k];
`endif
            mcopy--;
        end else if (mpend) begin
            if (frame_end) begin
                msel ^= 1; mpend = 0; msw = 1; mcopy = D;
            end
        end else begin
            if (wr_valid) mb[msel ^ 1][wr_addr] = wr_data;
            if (commit) mpend = 1;
        end
    endtask

    task automatic drv(input logic wv, input logic [2:0] wa, input logic [31:0] wd,
                       input logic cm, input logic fe, input logic [2:0] ra);
        wr_valid = wv; wr_addr = wa; wr_data = wd; commit = cm; frame_end = fe; rd_addr = ra;
    endtask

    // one clock: model advances on the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_rd_data", rd_data, mrd);
        chk("m_bank_sel", 32'(bank_sel), 32'(msel));
        chk("m_wr_ready", 32'(wr_ready), 32'(!mpend && mcopy == 0));
        chk("m_swap_pending", 32'(swap_pending), 32'(mpend));
        chk("m_swapped", 32'(swapped), 32'(msw));
    endtask

    // run with frame_end asserted whenever a swap is waiting until back in IDLE
    task automatic drain();
        for (int i = 0; i < 3 * D && (mpend || mcopy > 0); i++) begin
            drv(0, 0, 0, 0, mpend, 3'(i));
            cycle();
        end
        drv(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_bank_sel", 32'(bank_sel), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_swap_pending", 32'(swap_pending), 0);
        chk("rst_swapped", 32'(swapped), 0);
        rst_n = 1'b1;

        for (int a = 0; a < D; a++) begin
            drv(0, 0, 0, 0, 0, 3'(a));
            cycle();
            chk("rst_read_all", rd_data, 0);
        end

        // directed table: publish one entry, check copy window and front stability
        tbl.push_back('{1'b1, 3'd2, 32'h1404_2000, 1'b0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b1, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b0, 1'b0, 3'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 3'd2, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < D - 1; i++)
            tbl.push_back('{1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd2, 32'h1404_2000, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b0, 1'b0, 3'd2, 32'h1404_2000, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h0,         1'b0, 1'b0, 3'd2, 32'h1404_2000, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 3'd2, 32'h1404_2000, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 3'd2, 32'h1404_2000, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h0,         1'b0, 1'b0, 3'd3, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            drv(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].cm, tbl[i].fe, tbl[i].ra);
            cycle();
            chk("tbl_rd_data", rd_data, tbl[i].e_rd);
            chk("tbl_bank_sel", 32'(bank_sel), 32'(tbl[i].e_sel));
            chk("tbl_wr_ready", 32'(wr_ready), 32'(tbl[i].e_rdy));
            chk("tbl_swapped", 32'(swapped), 32'(tbl[i].e_sw));
            chk("tbl_swap_pending", 32'(swap_pending), 32'(tbl[i].e_pend));
        end

        // write held through PENDING and COPY lands only on the first IDLE cycle
        drv(0, 0, 0, 1, 0, 5); cycle();
        drv(1, 5, 32'hFFFF_FFFF, 0, 0, 5); cycle();
        drv(1, 5, 32'hFFFF_FFFF, 0, 1, 5); cycle();
        for (int i = 0; i < D + 1; i++) begin
            drv(1, 5, 32'hFFFF_FFFF, 0, 0, 5); cycle();
        end
        drv(0, 0, 0, 0, 0, 5); cycle();
        checks++;
        if (rd_data === 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL held_write_in_front actual=%h required=not ffffffff", rd_data);
        end
        drv(0, 0, 0, 1, 0, 5); cycle();
        drv(0, 0, 0, 0, 1, 5); cycle();
        drv(0, 0, 0, 0, 0, 5); cycle();
        chk("held_write_next_frame", rd_data, 32'hFFFF_FFFF);
        drain();

        // write + commit + frame_end together: swap waits for the next frame_end
        drv(1, 6, 32'hA5A5_0006, 1, 1, 6); cycle();
        chk("same_cycle_pending", 32'(swap_pending), 1);
        chk("same_cycle_no_swap", 32'(swapped), 0);
        drv(0, 0, 0, 0, 1, 6); cycle();
        chk("same_cycle_swapped", 32'(swapped), 1);
        drv(0, 0, 0, 0, 0, 6); cycle();
        chk("same_cycle_included", rd_data, 32'hA5A5_0006);
        drain();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            drv(1'($urandom_range(0, 1)), 3'($urandom), $urandom,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0), 3'($urandom));
            cycle();
        end
        drain();

        // reset while COPY is at index 4
        drv(1, 1, 32'h1234_5678, 1, 0, 1); cycle();
        drv(0, 0, 0, 0, 1, 1); cycle();
        drv(0, 0, 0, 0, 0, 1);
        repeat (4) cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midcopy_rst_bank_sel", 32'(bank_sel), 0);
        chk("midcopy_rst_rd_data", rd_data, 0);
        chk("midcopy_rst_wr_ready", 32'(wr_ready), 1);
        chk("midcopy_rst_swapped", 32'(swapped), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < D; a++) begin
            drv(0, 0, 0, 0, 0, 3'(a));
            cycle();
            chk("midcopy_rst_zero", rd_data, 0);
        end
        // after a bare swap the back (now front) must be all zero
        drv(0, 0, 0, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 1, 0); cycle();
        for (int a = 0; a < D; a++) begin
            drv(0, 0, 0, 0, 0, 3'(a));
            cycle();
            chk("post_rst_swap_zero", rd_data, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
